exp_pipe_control: RTL and testbench
===================================

EXP_PIPE_CONTROL -- requirements
Module: exp_pipe_control

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of datapath register stages sequenced (legal 2..8).
REQ-002 SHALL have parameter CNT_W, default 3, width of stage counter (2^CNT_W >= NUM_STAGES).
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  enables leaving IDLE when an operand is pending.
REQ-006 SHALL have port abort  input  1  synchronous abort of the current operation.
REQ-007 SHALL have port load_input  input  1  upstream offers an operand this cycle.
REQ-008 SHALL have port input_ready  output  1  operand accepted when load_input high.
REQ-009 SHALL have port stage_en  output  NUM_STAGES  one-hot datapath register enables.
REQ-010 SHALL have port out_valid  output  1  result held and valid.
REQ-011 SHALL have port out_accept  input  1  downstream takes result.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port overrun  output  1  sticky: load_input seen while input_ready low.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; RUN is indexed by counter stg (0..NUM_STAGES-1).
REQ-015 SHALL hold a pending flag: set on load_input && input_ready, cleared at the edge entering RUN stg=0 unless a new load occurs on the same edge (pending stays 1).
REQ-016 SHALL drive input_ready = !pending || consume, consume being high in the cycle whose edge enters RUN stg=0.
REQ-017 IDLE -> RUN stg=0 when start && pending; otherwise stay in IDLE.
REQ-018 RUN stg=k, k<NUM_STAGES-1 -> RUN stg=k+1; RUN stg=NUM_STAGES-1 -> DONE.
REQ-019 In RUN, stage_en SHALL equal 1<<stg; stage_en SHALL be all-zero in IDLE and DONE.
REQ-020 In DONE, out_valid SHALL be 1; stay while !out_accept; on out_accept -> RUN stg=0 if pending (back-to-back, start ignored), else IDLE.
REQ-021 Latency: start && pending sampled in IDLE at edge T -> out_valid first high after edge T+NUM_STAGES.
REQ-022 abort SHALL force IDLE next edge from any state, clear pending and stg, and has priority over all transitions and over a same-cycle load (operand dropped, input_ready low that cycle).
REQ-023 overrun SHALL set on load_input && !input_ready and stay set until reset; it SHALL NOT alter state or pending.
REQ-024 stg SHALL never exceed NUM_STAGES-1; any unreachable state encoding SHALL recover to IDLE next edge.

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, stg 0, pending 0, overrun 0; hence input_ready 1, stage_en 0, out_valid 0, busy 0.
REQ-026 Reset asserted mid-operation SHALL discard the operation with no further stage_en pulse; first legal transition is on the first rising CLK edge after rst_n rises.

Configuration
REQ-027 Macro EXP_CTRL_DEBUG_EN defined: SHALL add output d_state (2 bits: IDLE=0, RUN=1, DONE=2) and output d_stg (CNT_W bits) mirroring internal state and counter.
REQ-028 Macro EXP_CTRL_DEBUG_EN undefined: d_state and d_stg SHALL not exist; all other behaviour identical.

Verification
REQ-029 NUM_STAGES=4: load_input at cycle 0, start at cycle 1 -> stage_en 0001,0010,0100,1000 on cycles 2-5, out_valid from cycle 6, IDLE after out_accept.
REQ-030 Back-to-back: second load while RUN, out_accept in first DONE cycle -> RUN stg=0 next cycle with start low, no idle gap.
REQ-031 out_accept held low 5 cycles in DONE -> out_valid stays 1, stage_en 0, second load accepted once then input_ready low, third load sets overrun.
REQ-032 abort at RUN stg=2 with simultaneous load_input -> IDLE next cycle, pending 0, no further stage_en, overrun 0.
REQ-033 rst_n pulsed low mid-cycle in RUN stg=1 -> outputs reset immediately without clock edge, overrun cleared.
REQ-034 NUM_STAGES=2 and 8 regressions -> one-hot sequence length matches, latency = NUM_STAGES per REQ-021.

Source files
------------

// File: rtl/exp_pipe_control.sv
// Control sequencer for a NUM_STAGES-deep exponent datapath: IDLE -> RUN (one stage enable per cycle) -> DONE.
// Optional debug outputs d_state/d_stg exist only when EXP_CTRL_DEBUG_EN is defined.
module exp_pipe_control #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  load_input,
    output logic                  input_ready,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  out_valid,
    input  logic                  out_accept,
    output logic                  busy,
    output logic                  overrun
`ifdef EXP_CTRL_DEBUG_EN
    ,
    output logic [1:0]            d_state,
    output logic [CNT_W-1:0]      d_stg
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_STG = CNT_W'(NUM_STAGES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stg_q, stg_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             consume;
    logic             load_acc;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            stg_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stg_q     <= stg_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // consume marks the cycle whose edge enters RUN stg=0; abort suppresses it
    always_comb begin
        consume = 1'b0;
        case (state_q)
            S_IDLE:  consume = start & pending_q;
            S_DONE:  consume = out_accept & pending_q;
            default: consume = 1'b0;
        endcase
        consume = consume & ~abort;
    end

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        if (abort) begin
            state_d = S_IDLE;
            stg_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    stg_d = '0;
                    if (consume) state_d = S_RUN;
                end
                S_RUN: begin
                    if (stg_q == LAST_STG) begin
                        state_d = S_DONE;
                        stg_d   = '0;
                    end else if (stg_q < LAST_STG) begin
                        stg_d = stg_q + 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        stg_d   = '0;
                    end
                end
                S_DONE: begin
                    stg_d = '0;
                    if (out_accept) state_d = consume ? S_RUN : S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    stg_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        input_ready = ~abort & (~pending_q | consume);
        out_valid   = (state_q == S_DONE);
        busy        = (state_q != S_IDLE);
        stage_en    = '0;
        if (state_q == S_RUN && stg_q <= LAST_STG) begin
            stage_en = NUM_STAGES'(1) << stg_q;
        end
    end

    // a new load on the consuming edge keeps pending set; overrun ignores aborted cycles
    always_comb begin
        load_acc  = load_input & input_ready;
        overrun_d = overrun_q | (load_input & ~input_ready & ~abort);
        pending_d = pending_q;
        if (abort) begin
            pending_d = 1'b0;
        end else if (load_acc) begin
            pending_d = 1'b1;
        end else if (consume) begin
            pending_d = 1'b0;
        end
    end

    assign overrun = overrun_q;

`ifdef EXP_CTRL_DEBUG_EN
    assign d_state = state_q;
    assign d_stg   = stg_q;
`endif

endmodule

// File: tb/tb_exp_pipe_control.sv
// Bench for exp_pipe_control: three instances (NUM_STAGES 2, 4, 8) share stimulus and are
// compared every cycle against a countdown-based reference model; directed scenarios then random traffic.
module tb_exp_pipe_control;

    logic CLK = 1'b0;
    logic rst_n, start, abort, load_input, out_accept;
    wire [2:0] ir_v, ov_v, bs_v, or_v;
    wire [1:0] se2;
    wire [3:0] se4;
    wire [7:0] se8;

    int npass = 0, nfail = 0, ntotal = 0;
    int NS[3] = '{2, 4, 8};
    int rem[3];
    bit m_done[3], m_pend[3], m_ovr[3];

    always #5 CLK = ~CLK;

    exp_pipe_control #(.NUM_STAGES(2), .CNT_W(1)) u2 (
        .CLK(CLK), .rst_n(rst_n), .start(start), .abort(abort), .load_input(load_input),
        .input_ready(ir_v[0]), .stage_en(se2), .out_valid(ov_v[0]), .out_accept(out_accept),
        .busy(bs_v[0]), .overrun(or_v[0]));
    exp_pipe_control #(.NUM_STAGES(4), .CNT_W(3)) u4 (
        .CLK(CLK), .rst_n(rst_n), .start(start), .abort(abort), .load_input(load_input),
        .input_ready(ir_v[1]), .stage_en(se4), .out_valid(ov_v[1]), .out_accept(out_accept),
        .busy(bs_v[1]), .overrun(or_v[1]));
    exp_pipe_control #(.NUM_STAGES(8), .CNT_W(3)) u8 (
        .CLK(CLK), .rst_n(rst_n), .start(start), .abort(abort), .load_input(load_input),
        .input_ready(ir_v[2]), .stage_en(se8), .out_valid(ov_v[2]), .out_accept(out_accept),
        .busy(bs_v[2]), .overrun(or_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_se(input int k);
        case (k)
            0:       return {6'b0, se2};
            1:       return {4'b0, se4};
            default: return se8;
        endcase
    endfunction

    // Model: rem = RUN cycles still to go (0 = not running), m_done = result held.
    function automatic bit m_consume(input int k);
        bit idle = (rem[k] == 0) && !m_done[k];
        return !abort && m_pend[k] && ((idle && start) || (m_done[k] && out_accept));
    endfunction

    function automatic bit m_ready(input int k);
        return !abort && (!m_pend[k] || m_consume(k));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0; m_done[k] = 0; m_pend[k] = 0; m_ovr[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit c = m_consume(k);
            bit r = m_ready(k);
            if (abort) begin
                rem[k] = 0; m_done[k] = 0; m_pend[k] = 0;
            end else begin
                if (load_input && !r) m_ovr[k] = 1;
                if (c) begin
                    rem[k] = NS[k]; m_done[k] = 0;
                end else if (rem[k] > 0) begin
                    rem[k]--;
                    if (rem[k] == 0) m_done[k] = 1;
                end else if (m_done[k] && out_accept) begin
                    m_done[k] = 0;
                end
                if (load_input && r) m_pend[k] = 1;
                else if (c) m_pend[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] e_se = (rem[k] > 0) ? (8'd1 << (NS[k] - rem[k])) : 8'd0;
            chk($sformatf("ready_N%0d", NS[k]), 32'(ir_v[k]), 32'(m_ready(k)));
            chk($sformatf("stage_en_N%0d", NS[k]), 32'(dut_se(k)), 32'(e_se));
            chk($sformatf("out_valid_N%0d", NS[k]), 32'(ov_v[k]), 32'(m_done[k]));
            chk($sformatf("busy_N%0d", NS[k]), 32'(bs_v[k]), 32'((rem[k] > 0) || m_done[k]));
            chk($sformatf("overrun_N%0d", NS[k]), 32'(or_v[k]), 32'(m_ovr[k]));
        end
    endtask

    task automatic cyc(input bit ld, input bit st, input bit ab, input bit acc);
        load_input = ld; start = st; abort = ab; out_accept = acc;
        #2;
        check_all();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        load_input = 0; start = 0; abort = 0; out_accept = 0;
        #3 rst_n = 0;
        #1 model_reset();
        check_all();
        #2 rst_n = 1;
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0; load_input = 0; out_accept = 0;
        model_reset();
        #1;
        check_all();
        chk("reset_ready4", 32'(ir_v[1]), 32'd1);
        chk("reset_se4", 32'(se4), 32'd0);
        @(posedge CLK);
        #3 rst_n = 1;

        // basic sequence: load cycle 0, start cycle 1, stages cycles 2-5, valid cycle 6
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("seq4_stage_en", 32'(se4), 32'd1 << i);
            cyc(0, 0, 0, 0);
        end
        chk("seq4_out_valid", 32'(ov_v[1]), 32'd1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("seq4_idle_after_accept", 32'(bs_v[1]), 32'd0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

        // back-to-back: second load while running, accept in first DONE cycle
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        chk("b2b_done4", 32'(ov_v[1]), 32'd1);
        cyc(0, 0, 0, 1);
        chk("b2b_restart4", 32'(se4), 32'd1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1);

        // held result: extra loads while waiting, third one overruns
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        chk("hold_valid4", 32'(ov_v[1]), 32'd1);
        chk("hold_overrun4", 32'(or_v[1]), 32'd1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1);

        // abort at stage 2 together with a load
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("abort_at_stg2", 32'(se4), 32'd4);
        cyc(1, 0, 1, 0);
        chk("abort_idle4", 32'(bs_v[1]), 32'd0);
        chk("abort_overrun4", 32'(or_v[1]), 32'd0);
        cyc(0, 1, 0, 0);
        chk("abort_no_pending4", 32'(bs_v[1]), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

        // async reset in the middle of stage 1 clears an earlier overrun
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("pre_reset_stg1", 32'(se4), 32'd2);
        chk("pre_reset_overrun", 32'(or_v[1]), 32'd1);
        #3 rst_n = 0;
        #1 model_reset();
        check_all();
        chk("midreset_se4", 32'(se4), 32'd0);
        chk("midreset_overrun4", 32'(or_v[1]), 32'd0);
        #2 rst_n = 1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)),
                ($urandom_range(19, 0) == 0), ($urandom_range(9, 0) < 4));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
